// File: rtl/sample_out_pkg.sv
// Shared types and constants for the serial sample output stage.
package sample_out_pkg;

  localparam int unsigned SAMPLE_W  = 32;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned ENTRY_W   = SAMPLE_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_t;

  typedef struct packed {
    logic                tag;
    logic [SAMPLE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of tagged samples; head is read combinationally.
module sample_fifo
  import sample_out_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly AW bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/sample_serializer.sv
// Buffers tagged samples and shifts them MSB-first onto an sclk/lrck/sdata link.
module sample_serializer
  import sample_out_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CLKDIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic                modeSelector,
  input  logic [SAMPLE_W-1:0] Data,
  output logic                sclk,
  output logic                lrck,
  output logic                sdata,
  output logic                full,
  output logic                empty,
  output logic                busy,
  output logic                overflow
);

  localparam int unsigned DW = $clog2(2 * CLKDIV) + 1;
  localparam int unsigned BW = $clog2(WORD_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(2 * CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);

  ser_state_t           state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 sclk_q, sclk_d;
  logic                 sdata_q, sdata_d;
  logic                 lrck_q, lrck_d;
  logic                 overflow_q, overflow_d;

  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   fifo_dout;
  fifo_entry_t          head;

  // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push       = write & ~full;
  assign overflow_d = overflow_q | (write & full);
  assign head       = fifo_entry_t'(fifo_dout);

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({modeSelector, Data}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    lrck_d  = lrck_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head.data;
          lrck_d  = head.tag;
          sdata_d = head.data[WORD_BITS-1];
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Data changes only on the falling toggle so it is centred on the rise.
          if (sclk_q) begin
            if (bit_q == BIT_LAST) begin
              sdata_d = 1'b0;
              state_d = GAP;
            end else begin
              shreg_d = shreg_q << 1;
              bit_d   = bit_q + 1'b1;
              sdata_d = shreg_q[WORD_BITS-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      lrck_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      lrck_q     <= lrck_d;
      overflow_q <= overflow_d;
    end
  end

  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign lrck     = lrck_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench: word-level reference model predicts FIFO state and serial words.
module tb_sample_serializer;

  localparam int DEPTH    = 4;
  localparam int CLKDIV   = 2;
  localparam int WORD_CYC = 66 * CLKDIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic        mode_sel;
  logic [31:0] data;
  logic        sclk, lrck, sdata, full, empty, busy, overflow;

  sample_serializer #(
    .DEPTH  (DEPTH),
    .CLKDIV (CLKDIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .modeSelector (mode_sel),
    .Data         (data),
    .sclk         (sclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tag;
    logic [31:0] data;
    int          start;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Reference model: queue contents, remaining busy cycles of the current word.
  logic [32:0] mq[$];
  exp_t        sb[$];
  int          m_rem  = 0;
  bit          m_ovf  = 0;
  bit          m_lrck = 0;
  bit          chk_en = 0;
  int          m_sz;
  logic [32:0] m_e;
  exp_t        m_x;

  // Monitor state
  logic        prev_sclk = 1'b0;
  int          nbits = 0;
  logic [31:0] word;
  logic        wtag;
  int          wstart;
  exp_t        got_x;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      m_rem  = 0;
      m_ovf  = 0;
      m_lrck = 0;
    end else begin
      m_sz = mq.size();
      if (m_rem > 0) begin
        m_rem--;
      end else if (m_sz > 0) begin
        m_e = mq.pop_front();
        m_x.tag   = m_e[32];
        m_x.data  = m_e[31:0];
        m_x.start = cyc + 1 + CLKDIV;
        sb.push_back(m_x);
        m_rem  = WORD_CYC;
        m_lrck = m_e[32];
      end
      if (write) begin
        if (m_sz < DEPTH) mq.push_back({mode_sel, data});
        else m_ovf = 1;
      end
    end
    chk_en = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_rem != 0);
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("lrck", lrck, m_lrck);
      if (m_rem <= 2 * CLKDIV) begin
        chk("sclk_quiet", sclk, 1'b0);
        chk("sdata_quiet", sdata, 1'b0);
      end
      if (sclk && !prev_sclk) begin
        if (nbits == 0) begin
          wstart = cyc;
          wtag   = lrck;
        end
        word = {word[30:0], sdata};
        nbits++;
        if (nbits == 32) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", word, cyc);
          end else begin
            got_x = sb.pop_front();
            chk("word_data", word, got_x.data);
            chk("word_tag", wtag, got_x.tag);
            chk("word_start", wstart, got_x.start);
          end
          nbits = 0;
        end
      end
      prev_sclk = sclk;
      if (rst) nbits = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic t);
    write    = 1'b1;
    data     = d;
    mode_sel = t;
    tick();
  endtask

  task automatic nop(input int n);
    write = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    write = 1'b0;
    while (!(busy == 1'b0 && empty == 1'b1) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_idle_timeout: got busy=%0b empty=%0b expected idle within %0d cycles",
               busy, empty, max);
    end
  endtask

  initial begin
    rst      = 1'b1;
    write    = 1'b1;
    mode_sel = 1'b1;
    data     = 32'hDEAD_BEEF;
    repeat (3) tick();
    rst = 1'b0;
    nop(2);

    put(32'hA5A5_0F01, 1'b1);
    wait_idle(400);
    nop(3);

    put(32'd1, 1'b0);
    put(32'd2, 1'b1);
    put(32'd3, 1'b0);
    wait_idle(3 * (WORD_CYC + 1) + 50);
    nop(3);

    for (int i = 10; i <= 15; i++) put(32'(i), i[0]);
    // Keep writing through several pops taken while full.
    for (int i = 0; i < 300; i++) put($urandom, 1'($urandom));
    wait_idle((DEPTH + 2) * (WORD_CYC + 1));
    nop(3);

    for (int i = 0; i < 1500; i++) begin
      write    = ($urandom_range(0, 99) < 3);
      data     = $urandom;
      mode_sel = 1'($urandom);
      tick();
    end
    wait_idle((DEPTH + 2) * (WORD_CYC + 1));
    nop(3);

    put(32'hFFFF_FFFF, 1'b1);
    put($urandom, 1'b0);
    put($urandom, 1'b1);
    write = 1'b0;
    begin
      int n;
      n = 0;
      while (nbits != 15 && n < 300) begin
        tick();
        n++;
      end
      checks++;
      if (n >= 300) begin
        errors++;
        $display("FAIL bit15_timeout: got nbits=%0d expected 15", nbits);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop(200);

    put(32'h1234_5678, 1'b0);
    wait_idle(400);
    nop(5);

    chk("sb_drained", sb.size(), 0);
    chk("no_partial_word", nbits, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Downstream output stage of the reverberation processor. Captures each 32-bit processed sample presented on `Data` while `write` is high, tagged with the `modeSelector` value active at capture. Buffers samples in a small FIFO and serializes them MSB-first onto a three-wire audio link (`sclk`/`lrck`/`sdata`) for the DAC or capture hardware. The tag drives `lrck`, so output-1 and output-2 streams remain distinguishable downstream.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CLKDIV`, 4: `clk` cycles per `sclk` half-period; ≥1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `write`  in  1  sample strobe; one sample captured per cycle while high.
- `modeSelector`  in  1  stream tag captured with the sample.
- `Data`  in  32  processed sample.
- `sclk`  out  1  serial bit clock; receiver samples on its rising edge.
- `lrck`  out  1  tag of the word currently shifting.
- `sdata`  out  1  serial data, MSB first.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  serializer not in IDLE.
- `overflow`  out  1  sticky; a sample was dropped.

## Operation
- Reset: `sclk`=0, `lrck`=0, `sdata`=0, `full`=0, `empty`=1, `busy`=0, `overflow`=0. FIFO pointers and count are cleared. FSM enters IDLE. Reset in mid-word aborts the word immediately.
- Push: on `write`=1 with `full`=0, the FIFO stores {`modeSelector`,`Data`}.
  - `write`=1 with `full`=1 drops the sample and sets `overflow`. This holds even when a pop happens in the same cycle.
  - `overflow` clears only on `rst`.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: `sclk`=0, `sdata`=0, `lrck` holds its last value. If `empty`=0: pop the head, load the shift register, set `lrck`=tag, drive `sdata`=bit31, clear the divider and bit counter, go to SHIFT.
  - SHIFT: the divider counts 0..CLKDIV-1; at terminal count it wraps and `sclk` toggles.
    - On a falling toggle with bitcnt<31: shift left, bitcnt+1, `sdata`=next bit.
    - On a falling toggle with bitcnt=31: `sdata`=0, go to GAP.
  - GAP: `sclk`=0, `sdata`=0 for 2·CLKDIV cycles, then IDLE.
- `busy`=1 in SHIFT and GAP.
- Arithmetic: count width is log2(DEPTH)+1. Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- `full` and `empty` are registered and reflect pushes and pops of the previous cycle.
- Latency, with a write in cycle N into an idle, empty block:
  - N+1: `empty`=0, IDLE pops.
  - N+2: `sdata`=bit31, `lrck`=tag, `busy`=1.
  - N+2+CLKDIV: first `sclk` rise.
- Word timing:
  - 32 bit periods of 2·CLKDIV cycles each.
  - Bit k is stable from one `sclk` fall to the next, centred on the rising edge.
  - Gap of 2·CLKDIV cycles.
  - 1 IDLE cycle.
  - Total per word: 66·CLKDIV+1 cycles.
- Sustained input faster than one sample per 66·CLKDIV+1 cycles eventually fills the FIFO and sets `overflow`.

## Structure
- Package `sample_out_pkg`:
  - `SAMPLE_W`=32.
  - `WORD_BITS`=32.
  - typedef `ser_state_t` {IDLE, SHIFT, GAP}.
  - typedef `fifo_entry_t` packed {tag, data[31:0]}.
- Sub-module `sample_fifo`:
  - Synchronous FIFO parameterised by `DEPTH`, storing `fifo_entry_t`.
  - Ports: push, pop, din, dout (head, combinational read), full, empty.
- Top level holds the divider, bit counter, shift register, FSM and overflow flag.

## Test plan
All scenarios use DEPTH=4, CLKDIV=2.
- Reset check: hold `rst` 3 cycles while `write`=1 -> all outputs at reset values; no entry is stored.
- Single word: write `Data`=32'hA5A5_0F01 with `modeSelector`=1 -> `lrck`=1 from N+2; 32 bits sampled on `sclk` rises equal 32'hA5A5_0F01; `busy` falls 133 cycles after N+2 minus the IDLE cycle; `sdata`=0 in GAP.
- Back-to-back words: write 1, 2, 3 (tags 0, 1, 0) on consecutive cycles -> three words decoded in order as 1, 2, 3 with `lrck` 0, 1, 0; each word starts 133 cycles after the previous one.
- Overflow: 6 consecutive writes of 10..15 -> the first word pops at N+1, so 10..14 are accepted and 15 is dropped; `full`=1, `overflow`=1 and stays set; the serialized stream is 10, 11, 12, 13, 14.
- Push with pop at `full`=1: FIFO full, write coincides with an IDLE pop -> write is dropped, `overflow`=1, count becomes DEPTH-1.
- Reset mid-word: assert `rst` at bit 15 of 32'hFFFF_FFFF with 2 entries queued -> next cycle `sclk`=`sdata`=0, `empty`=1, `busy`=0, `overflow`=0; no further bits are emitted.
